// File: rtl/tpu_host_if.sv
// Host-side job driver for the convolution TPU: replays a kernel+matrix word
// stream into the TPU, then collects results through a small FIFO back to the host.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tpu_host_if #(
    parameter int MATRIX_DIM  = 16,
    parameter int CONV_DIM    = 3,
    parameter int DATA_WIDTH  = `DATA_WIDTH,
    parameter int NUM_RESULTS = (MATRIX_DIM - CONV_DIM + 1) * (MATRIX_DIM - CONV_DIM + 1),
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  job_done,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  insert_kernal,
    output logic                  insert_matrix,
    output logic [DATA_WIDTH-1:0] tpu_data_in,
    output logic                  tpu_ready,
    input  logic                  tpu_done,
    input  logic [DATA_WIDTH-1:0] tpu_data_out,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
);
    localparam int K_WORDS = CONV_DIM * CONV_DIM;
    localparam int M_WORDS = MATRIX_DIM * MATRIX_DIM;
    localparam int WCW     = $clog2(M_WORDS + 1);
    localparam int RCW     = $clog2(NUM_RESULTS + 1);
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int CW      = PW + 1;

    typedef enum logic [2:0] {IDLE, LOAD_K, LOAD_M, RUN, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [WCW-1:0]          word_cnt_q, word_cnt_d;
    logic [RCW-1:0]          res_cnt_q, res_cnt_d;
    logic                    ins_k_q, ins_m_q;
    logic [DATA_WIDTH-1:0]   din_q;
    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]           count_q;
    logic                    hs, push, pop;

    assign busy          = (state_q != IDLE);
    assign insert_kernal = ins_k_q;
    assign insert_matrix = ins_m_q;
    assign tpu_data_in   = din_q;
    assign m_valid       = (count_q != '0);
    assign m_data        = mem_q[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        res_cnt_d  = res_cnt_q;
        job_done   = 1'b0;
        s_ready    = (state_q == LOAD_K) || (state_q == LOAD_M);
        tpu_ready  = (state_q == RUN) && (count_q < CW'(FIFO_DEPTH));
        hs         = s_ready && s_valid;
        push       = tpu_ready && tpu_done;
        pop        = m_valid && m_ready;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD_K;
                    word_cnt_d = '0;
                    res_cnt_d  = '0;
                end
            end
            LOAD_K: begin
                if (hs) begin
                    if (word_cnt_q == WCW'(K_WORDS - 1)) begin
                        state_d    = LOAD_M;
                        word_cnt_d = '0;
                    end else begin
                        word_cnt_d = word_cnt_q + WCW'(1);
                    end
                end
            end
            LOAD_M: begin
                if (hs) begin
                    if (word_cnt_q == WCW'(M_WORDS - 1)) begin
                        state_d    = RUN;
                        word_cnt_d = '0;
                    end else begin
                        word_cnt_d = word_cnt_q + WCW'(1);
                    end
                end
            end
            RUN: begin
                if (push) begin
                    res_cnt_d = res_cnt_q + RCW'(1);
                    if (res_cnt_q == RCW'(NUM_RESULTS - 1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Done fires alongside the pop that empties the buffer.
                if ((count_q == '0) || (pop && count_q == CW'(1))) begin
                    job_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            res_cnt_q  <= '0;
            ins_k_q    <= 1'b0;
            ins_m_q    <= 1'b0;
            din_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            res_cnt_q  <= res_cnt_d;
            ins_k_q    <= hs && (state_q == LOAD_K);
            ins_m_q    <= hs && (state_q == LOAD_M);
            if (hs) din_q <= s_data;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
            always_ff @(posedge clk) begin
                if (!rst) begin
                    mem_q[gi] <= '0;
                end else if (push && wr_ptr_q == PW'(gi)) begin
                    mem_q[gi] <= tpu_data_out;
                end
            end
        end
    endgenerate
endmodule

// File: doc/tpu_host_if.md
Name: tpu_host_if

Overview:
- Host-side driver for the convolution TPU.
- Accepts one job as a valid/ready word stream: CONV_DIM² kernel words followed by MATRIX_DIM² matrix words.
- Replays the words into the TPU using its insert_kernal / insert_matrix / data_in strobes.
- Then runs the TPU with ready/done flow control, buffers each convolution result in a small FIFO, and streams results back to the host over valid/ready.

Parameters:
- MATRIX_DIM, 16, side length of the input matrix (matches TPU).
- CONV_DIM, 3, side length of the kernel (matches TPU).
- DATA_WIDTH, `DATA_WIDTH, width of every data word.
- NUM_RESULTS, (MATRIX_DIM-CONV_DIM+1)², results collected per job.
- FIFO_DEPTH, 4, result buffer entries; power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- start  in  1  one-cycle job launch; ignored unless IDLE.
- busy  out  1  high whenever state != IDLE.
- job_done  out  1  one-cycle pulse when the last result has been popped.
- s_valid  in  1  host input word valid.
- s_ready  out  1  block accepts an input word.
- s_data  in  DATA_WIDTH  host input word.
- insert_kernal  out  1  TPU kernel write strobe.
- insert_matrix  out  1  TPU matrix write strobe.
- tpu_data_in  out  DATA_WIDTH  word to TPU data_in.
- tpu_ready  out  1  TPU ready, i.e. permission to emit a result.
- tpu_done  in  1  TPU done; the result is valid this cycle.
- tpu_data_out  in  DATA_WIDTH  TPU result.
- m_valid  out  1  host output word valid.
- m_ready  in  1  host accepts the output word.
- m_data  out  DATA_WIDTH  result word, equal to the FIFO head.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state goes to IDLE; counters and FIFO are cleared.
  - All outputs are 0: busy, job_done, s_ready, insert_*, tpu_data_in, tpu_ready, m_valid, m_data.
  - Reset mid-job aborts the job; no job_done pulse is produced.
- FSM states: IDLE, LOAD_K, LOAD_M, RUN, DRAIN.
- IDLE:
  - start=1 moves to LOAD_K next cycle and clears word_cnt and res_cnt.
- LOAD_K / LOAD_M:
  - s_ready=1 combinationally.
  - An input handshake occurs when s_valid&s_ready.
  - On a handshake, the next cycle has insert_kernal (LOAD_K) or insert_matrix (LOAD_M) =1 and tpu_data_in = the accepted s_data. These outputs are registered, so latency is exactly 1 cycle.
  - Without a handshake, the strobe is 0 and tpu_data_in holds its last value.
  - word_cnt increments per handshake.
  - The handshake that brings word_cnt to CONV_DIM² moves LOAD_K→LOAD_M and zeroes word_cnt.
  - The handshake that brings word_cnt to MATRIX_DIM² moves LOAD_M→RUN.
  - Each state accepts exactly CONV_DIM² (LOAD_K) or MATRIX_DIM² (LOAD_M) words. Input stalls (s_valid=0) are allowed at any cycle.
- RUN:
  - tpu_ready = (fifo_count < FIFO_DEPTH), combinational; it is 0 in every other state.
  - tpu_done=1 with tpu_ready=1 pushes tpu_data_out into the FIFO and increments res_cnt.
  - tpu_done while tpu_ready=0 (or outside RUN) is ignored.
  - The push that brings res_cnt to NUM_RESULTS moves RUN→DRAIN.
- DRAIN:
  - No pushes occur.
  - When the FIFO becomes empty, the block pulses job_done for one cycle (same cycle as the final pop) and returns to IDLE.
- FIFO:
  - m_valid = (fifo_count != 0); m_data = the head entry.
  - A pop occurs on m_valid&m_ready. Pops are allowed in RUN and DRAIN.
  - A simultaneous push and pop leaves the count unchanged.
  - A push into a full FIFO cannot occur, because tpu_ready gates it.
  - The pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
  - Order is first-in, first-out.
- Width and count rules:
  - word_cnt is sized for MATRIX_DIM²; res_cnt is sized for NUM_RESULTS.
  - Data passes through unmodified; no arithmetic is applied.
- Other:
  - start while busy is ignored.
  - s_valid outside LOAD_* is ignored (s_ready=0).

Test Plan (MATRIX_DIM=4, CONV_DIM=2, NUM_RESULTS=9, FIFO_DEPTH=4 unless noted):
1. Streaming load:
   - Stimulus: start; stream kernel 1,2,3,4 then matrix 10..25 with s_valid held high.
   - Required response: insert_kernal high for 4 consecutive cycles carrying 1,2,3,4, one cycle after each handshake. insert_matrix then carries 10..25 over 16 cycles. State enters RUN the cycle after word 25 is accepted.
2. Throttled input:
   - Stimulus: same job with s_valid toggled 1,0,1,0.
   - Required response: strobes fire only on accepted words, exactly 4 + 16 in total. tpu_data_in holds its value during gaps.
3. Result flow with a stalled host:
   - Stimulus: in RUN, tpu_done each cycle with values 100..108; m_ready=0.
   - Required response: 4 pushes (100..103), then tpu_ready=0 and later tpu_done pulses are ignored.
   - Stimulus continued: raise m_ready.
   - Required response: m_data 100,101,… in order, with tpu_ready reasserting as space frees.
4. Push and pop together:
   - Stimulus: FIFO holds 2 entries; tpu_done=1 and m_ready=1 in the same cycle.
   - Required response: count stays 2; the new entry is appended behind the existing ones.
5. Completion:
   - Stimulus: complete all 9 results with m_ready=1.
   - Required response: job_done pulses exactly once, coincident with the pop of the 9th result; busy drops the next cycle. A start in that following cycle begins a new job.
6. Reset mid-job:
   - Stimulus: rst=0 while in LOAD_M with word_cnt=7; release reset.
   - Required response: all outputs 0 and state IDLE. start plus a fresh 20-word load behaves exactly as in scenario 1.
